piso_tx_scheduler: RTL and testbench

- Shares one 4-bit parallel-to-serial shifter between NREQ requesters.
- Round-robin arbitration picks a requester, captures its word, shifts it out MSB-first at a programmable bit rate, then reports completion.
- Sits between several parallel producers and a single serial link.
- The shift register is internal, so the block is the sequencer plus the shared datapath.

---
 rtl/piso_tx_scheduler.sv | 174 +++++++++++++++++
 tb/tb_piso_tx_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one parallel-to-serial shifter between NREQ requesters.
// Each granted word is shifted out MSB-first, one bit per BAUD_DIV cycles.
module piso_tx_scheduler #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned BAUD_DIV = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     din,
    output logic [NREQ-1:0]           gnt,
    output logic                      sout,
    output logic                      sout_valid,
    output logic                      frame_start,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]        r_state;
    logic [WIDTH-1:0]  r_shift;
    logic [CW-1:0]     r_bit_cnt;
    logic [BW-1:0]     r_baud_cnt;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_cur_id;
    logic [NREQ-1:0]   r_gnt;
    logic              r_sout;
    logic              r_sout_valid;
    logic              r_frame_start;
    logic              r_busy;
    logic              r_done;
    logic [IW-1:0]     r_done_id;

    logic              w_win_found;
    logic [IW-1:0]     w_win;
    logic [WIDTH-1:0]  w_win_word;

    logic [0:0]        w_state_n;
    logic [WIDTH-1:0]  w_shift_n;
    logic [CW-1:0]     w_bit_cnt_n;
    logic [BW-1:0]     w_baud_cnt_n;
    logic [IW-1:0]     w_ptr_n;
    logic [IW-1:0]     w_cur_id_n;
    logic [NREQ-1:0]   w_gnt_n;
    logic              w_frame_start_n;
    logic              w_valid_n;
    logic              w_done_n;

    // First requester at or above the pointer, searching upward modulo NREQ.
    always_comb begin
        int unsigned v_idx;
        v_idx       = 0;
        w_win_found = 1'b0;
        w_win       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            v_idx = 32'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_win_found && req[IW'(v_idx)]) begin
                w_win_found = 1'b1;
                w_win       = IW'(v_idx);
            end
        end
    end

    always_comb begin
        w_win_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IW'(i) == w_win) begin
                w_win_word = din[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        w_state_n       = r_state;
        w_shift_n       = r_shift;
        w_bit_cnt_n     = r_bit_cnt;
        w_baud_cnt_n    = r_baud_cnt;
        w_ptr_n         = r_ptr;
        w_cur_id_n      = r_cur_id;
        w_gnt_n         = '0;
        w_frame_start_n = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_n       = S_SHIFT;
                    w_shift_n       = w_win_word;
                    w_cur_id_n      = w_win;
                    w_bit_cnt_n     = '0;
                    w_baud_cnt_n    = '0;
                    w_gnt_n         = NREQ'(1) << w_win;
                    w_frame_start_n = 1'b1;
                    w_ptr_n         = (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);
                end
            end
            S_SHIFT: begin
                if (r_baud_cnt == BW'(BAUD_DIV - 1)) begin
                    w_baud_cnt_n = '0;
                    w_shift_n    = {r_shift[WIDTH-2:0], 1'b0};
                    if (r_bit_cnt == CW'(WIDTH - 1)) begin
                        w_state_n   = S_IDLE;
                        w_bit_cnt_n = '0;
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + CW'(1);
                    end
                end else begin
                    w_baud_cnt_n = r_baud_cnt + BW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_valid_n = (w_state_n == S_SHIFT);
        w_done_n  = w_valid_n && (w_bit_cnt_n == CW'(WIDTH - 1)) &&
                    (w_baud_cnt_n == BW'(BAUD_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_baud_cnt    <= '0;
            r_ptr         <= '0;
            r_cur_id      <= '0;
            r_gnt         <= '0;
            r_sout        <= 1'b0;
            r_sout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_done_id     <= '0;
        end else begin
            r_state       <= w_state_n;
            r_shift       <= w_shift_n;
            r_bit_cnt     <= w_bit_cnt_n;
            r_baud_cnt    <= w_baud_cnt_n;
            r_ptr         <= w_ptr_n;
            r_cur_id      <= w_cur_id_n;
            r_gnt         <= w_gnt_n;
            r_sout        <= w_valid_n & w_shift_n[WIDTH-1];
            r_sout_valid  <= w_valid_n;
            r_frame_start <= w_frame_start_n;
            r_busy        <= w_valid_n;
            r_done        <= w_done_n;
            if (w_done_n) begin
                r_done_id <= w_cur_id_n;
            end
        end
    end

    assign gnt         = r_gnt;
    assign sout        = r_sout;
    assign sout_valid  = r_sout_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign done_id     = r_done_id;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed scoreboard bench for piso_tx_scheduler: a BAUD_DIV=1 instance for
// arbitration/framing and a BAUD_DIV=3 instance for bit stretching.
module tb_piso_tx_scheduler;

    typedef struct {
        logic [1:0] id;
        logic [3:0] word;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic        sout, sout_valid, frame_start, busy, done;
    logic [1:0]  done_id;

    logic [3:0]  req3;
    logic [15:0] din3;
    logic [3:0]  gnt3;
    logic        sout3, sout_valid3, frame_start3, busy3, done3;
    logic [1:0]  done_id3;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    piso_tx_scheduler #(.WIDTH(4), .NREQ(4), .BAUD_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
        .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start),
        .busy(busy), .done(done), .done_id(done_id)
    );

    piso_tx_scheduler #(.WIDTH(4), .NREQ(4), .BAUD_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .din(din3), .gnt(gnt3),
        .sout(sout3), .sout_valid(sout_valid3), .frame_start(frame_start3),
        .busy(busy3), .done(done3), .done_id(done_id3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        req3 = '0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        chk("gap_valid", 32'(sout_valid), 0);
        chk("gap_sout",  32'(sout), 0);
        chk("gap_busy",  32'(busy), 0);
        chk("gap_gnt",   32'(gnt), 0);
        chk("gap_done",  32'(done), 0);
    endtask

    // Waits for a grant, pops the expected frame and checks it bit by bit.
    task automatic check_frame(input bit clr, input bit mess, output int waited);
        exp_t e;
        bit   seen;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            waited++;
            if (gnt != 4'b0000) seen = 1'b1;
        end
        chk("gnt_seen", 32'(seen), 1);
        if (!seen) return;
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (clr) req[e.id] = 1'b0;
        chk("gnt_onehot", 32'(gnt), 32'(4'b0001 << e.id));
        chk("frame_start", 32'(frame_start), 1);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            if (mess && b == 0) req[1] = 1'b1;
            if (mess && b == 2) begin
                req[1]    = 1'b0;
                din[11:8] = ~din[11:8];
            end
            chk("sout_valid", 32'(sout_valid), 1);
            chk("busy", 32'(busy), 1);
            chk("sout_bit", 32'(sout), 32'(e.word[3-b]));
            chk("done", 32'(done), 32'(b == 3));
            if (b > 0) chk("gnt_low", 32'(gnt), 0);
            if (b == 3) chk("done_id", 32'(done_id), 32'(e.id));
        end
    endtask

    initial begin
        int          w;
        bit          seen;
        logic [11:0] pat;

        clk  = 1'b0;
        rst  = 1'b1;
        req  = '0;
        din  = '0;
        req3 = '0;
        din3 = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt",   32'(gnt), 0);
        chk("rst_sout",  32'(sout), 0);
        chk("rst_valid", 32'(sout_valid), 0);
        chk("rst_fs",    32'(frame_start), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_id",    32'(done_id), 0);
        rst = 1'b0;

        // Single request from requester 1
        din[7:4] = 4'b1011;
        sb.push_back('{2'd1, 4'b1011});
        req = 4'b0010;
        check_frame(1'b1, 1'b0, w);
        gap();
        gap();

        // Round robin with all requesting
        reset_dut();
        din = 16'h8421;
        sb.push_back('{2'd0, 4'h1});
        sb.push_back('{2'd1, 4'h2});
        sb.push_back('{2'd2, 4'h4});
        sb.push_back('{2'd3, 4'h8});
        sb.push_back('{2'd0, 4'h1});
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            check_frame(1'b0, 1'b0, w);
            if (f > 0) chk("rr_one_idle", 32'(w), 1);
            if (f == 4) req = 4'b0000;
            gap();
        end

        // Pointer skip: serve 2, then 0 and 1 requested
        sb.push_back('{2'd2, 4'h4});
        req = 4'b0100;
        check_frame(1'b1, 1'b0, w);
        gap();
        sb.push_back('{2'd0, 4'h1});
        sb.push_back('{2'd1, 4'h2});
        req = 4'b0011;
        check_frame(1'b1, 1'b0, w);
        gap();
        check_frame(1'b1, 1'b0, w);
        chk("skip_one_idle", 32'(w), 1);
        gap();

        // Baud divide of 3 on the second instance
        din3[3:0] = 4'b1001;
        pat       = 12'b111000000111;
        req3      = 4'b0001;
        seen      = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (gnt3 != 4'b0000) seen = 1'b1;
        end
        chk("b3_gnt_seen", 32'(seen), 1);
        req3 = 4'b0000;
        chk("b3_gnt", 32'(gnt3), 32'h1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk("b3_valid", 32'(sout_valid3), 1);
            chk("b3_sout", 32'(sout3), 32'(pat[11-k]));
            chk("b3_done", 32'(done3), 32'(k == 11));
            if (k == 11) chk("b3_done_id", 32'(done_id3), 0);
        end
        @(negedge clk);
        chk("b3_after_valid", 32'(sout_valid3), 0);

        // Reset in the second bit of a frame
        din[3:0] = 4'hA;
        req      = 4'b0001;
        seen     = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 4'b0000) seen = 1'b1;
        end
        chk("mr_gnt_seen", 32'(seen), 1);
        chk("mr_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("mr_bit2", 32'(sout), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_gnt0",   32'(gnt), 0);
        chk("mr_sout0",  32'(sout), 0);
        chk("mr_valid0", 32'(sout_valid), 0);
        chk("mr_fs0",    32'(frame_start), 0);
        chk("mr_busy0",  32'(busy), 0);
        chk("mr_done0",  32'(done), 0);
        chk("mr_id0",    32'(done_id), 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mr_no_done", 32'(done), 0);
            chk("mr_no_gnt", 32'(gnt), 0);
        end
        din[15:12] = 4'h5;
        sb.push_back('{2'd3, 4'h5});
        req = 4'b1000;
        check_frame(1'b1, 1'b0, w);
        gap();

        // Transient req[1] and late din change during a frame of requester 2
        din[11:8] = 4'b0110;
        sb.push_back('{2'd2, 4'b0110});
        req = 4'b0100;
        check_frame(1'b1, 1'b1, w);
        gap();
        repeat (4) begin
            @(negedge clk);
            chk("tr_no_gnt", 32'(gnt), 0);
            chk("tr_idle", 32'(sout_valid), 0);
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
